// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one 16-SCLK transaction of {addr, rw} followed by a data byte,
// with a start/done host handshake and MISO capture into rdata on reads.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int TOT_W = CMD_W + DATA_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       HALF_LAST = 5'(2 * TOT_W - 1);
    // Low half-period index that precedes the rise of the first data bit.
    localparam logic [4:0]       RX_FIRST  = 5'(2 * CMD_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    generate
        if (CLK_DIV < 4) begin : g_div_check
            $error("spi_master_ctrl: CLK_DIV must be at least 4");
        end
    endgenerate

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        half_cnt;
    logic [TOT_W-1:0]  tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              rw_q;
    logic              div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            sclk_pin <= 1'b0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        tx_sr    <= {addr, rw, rw ? {DATA_W{1'b0}} : wdata};
                        rw_q     <= rw;
                        mosi_pin <= addr[ADDR_W-1];
                        cs_pin   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        sclk_pin <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        // Even half-periods are SCLK high; their end is the falling edge.
                        if (!half_cnt[0]) begin
                            sclk_pin <= 1'b0;
                            mosi_pin <= tx_sr[TOT_W-2];
                            tx_sr    <= {tx_sr[TOT_W-2:0], 1'b0};
                            half_cnt <= half_cnt + 5'd1;
                        end else if (half_cnt == HALF_LAST) begin
                            state <= HOLD;
                        end else begin
                            sclk_pin <= 1'b1;
                            half_cnt <= half_cnt + 5'd1;
                            if (rw_q && half_cnt >= RX_FIRST) begin
                                rx_sr <= {rx_sr[DATA_W-2:0], miso_pin};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        cs_pin  <= 1'b1;
                        done    <= 1'b1;
                        if (rw_q) begin
                            rdata <= rx_sr;
                        end
                        state <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI memory slave, array reference model,
// latency and waveform checks, randomized read/write traffic.
module tb_spi_master_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int DONE_LAT = 1 + 34 * CLK_DIV;
    localparam int IDLE_LAT = 1 + 35 * CLK_DIV;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              busy, done, sclk_pin, cs_pin, mosi_pin;
    logic [DATA_W-1:0] rdata;
    logic              miso_pin = 1'b0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso_pin)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural SPI memory slave: samples MOSI on SCLK rise, drives MISO after falls.
    logic [7:0]  smem [0:127];
    logic [15:0] s_sh = '0;
    int          s_n = 0;
    logic [6:0]  s_addr = '0;
    logic        s_rw = 1'b0;
    logic [15:0] cap_bits = '0;
    int          cap_n = 0;

    initial for (int i = 0; i < 128; i++) smem[i] = 8'h00;

    always @(posedge sclk_pin or posedge cs_pin) begin
        if (cs_pin) begin
            cap_bits = s_sh;
            cap_n    = s_n;
            if (s_n == 16 && !s_rw) smem[s_addr] = s_sh[7:0];
            s_n  = 0;
            s_sh = '0;
        end else begin
            s_sh = {s_sh[14:0], mosi_pin};
            s_n++;
            if (s_n == 8) begin
                s_addr = s_sh[7:1];
                s_rw   = s_sh[0];
            end
        end
    end

    always @(negedge sclk_pin) begin
        logic [7:0] b;
        if (!cs_pin && s_rw && s_n >= 8 && s_n < 16) begin
            b = smem[s_addr];
            miso_pin = b[15-s_n];
        end
    end

    // Waveform monitor, sampled mid-cycle.
    int   wave_err = 0, n_done = 0, n_csfall = 0, last_gap = 0, hi_run = 0, run = 0;
    logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, low_trk = 1'b0;

    always @(negedge clk) begin
        if (done) n_done++;
        if (cs_pin && sclk_pin) wave_err++;
        if (cs_pin) hi_run++;
        else if (p_cs) begin
            n_csfall++;
            last_gap = hi_run;
            hi_run = 0;
        end
        if (sclk_pin != p_sclk) begin
            if (!cs_pin && p_sclk && run != CLK_DIV) wave_err++;
            if (!cs_pin && !p_sclk && low_trk && run != CLK_DIV) wave_err++;
            low_trk = p_sclk && !cs_pin;
            run = 1;
        end else begin
            run++;
        end
        if (cs_pin) low_trk = 1'b0;
        if (!cs_pin && !p_cs && mosi_pin != p_mosi && !(p_sclk && !sclk_pin)) wave_err++;
        p_sclk = sclk_pin;
        p_cs   = cs_pin;
        p_mosi = mosi_pin;
    end

    // Reference model state.
    logic [7:0]        exp_mem [0:127];
    logic [DATA_W-1:0] exp_rdata = '0;

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_txn(input logic rw_i, input logic [6:0] a_i, input logic [7:0] d_i);
        int unsigned t0;
        int k;
        logic [15:0] exp_bits;
        wait_idle(400);
        exp_bits = {a_i, rw_i, rw_i ? 8'h00 : d_i};
        rw = rw_i; addr = a_i; wdata = d_i; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_cs", {31'd0, cs_pin}, 32'd0);
        check("first_mosi", {31'd0, mosi_pin}, {31'd0, a_i[6]});
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            check("done_timeout", {31'd0, done}, 32'd1);
        end else begin
            if (rw_i) exp_rdata = exp_mem[a_i];
            else      exp_mem[a_i] = d_i;
            check("done_latency", cyc - t0, DONE_LAT);
            check("done_cs", {31'd0, cs_pin}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd1);
            check("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
            check("mosi_bits", {16'd0, cap_bits}, {16'd0, exp_bits});
            check("sclk_rises", cap_n, 16);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
            wait_idle(20);
            check("busy_latency", cyc - t0, IDLE_LAT);
            check("waveform", wave_err, 0);
        end
    endtask

    initial begin
        int base_done, base_fall, exp_n, tt;
        logic [6:0] a4;
        logic [7:0] d4;
        for (int i = 0; i < 128; i++) exp_mem[i] = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_sclk", {31'd0, sclk_pin}, 32'd0);
        check("rst_cs", {31'd0, cs_pin}, 32'd1);
        check("rst_mosi", {31'd0, mosi_pin}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset held for three cycles in the middle of a transaction.
        base_done = n_done;
        rw = 1'b0; addr = 7'h11; wdata = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs", {31'd0, cs_pin}, 32'd1);
        check("abort_sclk", {31'd0, sclk_pin}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", n_done - base_done, 0);
        check("abort_rdata", {24'd0, rdata}, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Reset and start together: nothing is accepted.
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        check("rst_start_cs", {31'd0, cs_pin}, 32'd1);

        // Directed write/read and boundary addresses.
        do_txn(1'b0, 7'h2A, 8'hC3);
        do_txn(1'b1, 7'h2A, 8'h99);
        do_txn(1'b0, 7'h00, 8'hFF);
        do_txn(1'b0, 7'h7F, 8'h00);
        do_txn(1'b1, 7'h00, 8'h00);
        do_txn(1'b1, 7'h7F, 8'hAA);
        do_txn(1'b0, 7'h7F, 8'h5A);

        // start held high: accepts occur only when idle, one per full busy period.
        a4 = 7'h33; d4 = 8'h6E;
        base_done = n_done; base_fall = n_csfall;
        rw = 1'b0; addr = a4; wdata = d4; start = 1'b1;
        repeat (250) @(negedge clk);
        start = 1'b0;
        exp_n = 0;
        tt = 0;
        while (tt < 250) begin
            exp_n++;
            tt += IDLE_LAT;
        end
        wait_idle(400);
        exp_mem[a4] = d4;
        check("held_start_txns", n_csfall - base_fall, exp_n);
        check("held_start_dones", n_done - base_done, exp_n);
        check("cs_gap_ok", {31'd0, last_gap >= CLK_DIV}, 32'd1);
        do_txn(1'b1, a4, 8'h00);

        // Randomized traffic, biased towards a small address set for read-back hits.
        for (int i = 0; i < 14; i++) begin
            do_txn(1'($urandom), 7'($urandom_range(0, 7) * 18), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
